// File: rtl/bcd_cuenta_regresiva.sv
// Multi-digit BCD countdown timer: chained mod-10 digits that decrement with
// borrow propagation, load a BCD preset and pulse fin on reaching zero.
module bcd_cuenta_regresiva #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cargar,
    input  logic [4*DIGITS-1:0]   valor,
    input  logic                  iniciar,
    input  logic                  pausar,
    input  logic                  decremento,
    output logic [4*DIGITS-1:0]   cuenta,
    output logic                  activo,
    output logic                  fin,
    output logic                  error_carga
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CORRIENDO = 2'd1,
        PAUSA     = 2'd2,
        FIN       = 2'd3
    } estado_t;

    estado_t        estado_r;
    logic [W-1:0]   cuenta_r;
    logic           activo_r;
    logic           fin_r;
    logic           error_carga_r;

    logic [W-1:0]   cuenta_dec_s;
    logic           valor_valido_s;
    logic           cuenta_cero_s;
    logic           dec_cero_s;

    // True when every nibble is a legal BCD digit (0..9).
    function automatic logic bcd_valido(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Subtract one: a zero digit under borrow becomes 9 and passes the borrow on.
    function automatic logic [W-1:0] bcd_decrementar(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        logic [3:0]   d;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    // Combinational helpers: decremented count and zero/validity flags.
    always_comb begin
        cuenta_dec_s   = bcd_decrementar(cuenta_r);
        valor_valido_s = bcd_valido(valor);
        cuenta_cero_s  = (cuenta_r == {W{1'b0}});
        dec_cero_s     = (cuenta_dec_s == {W{1'b0}});
    end

    // Control FSM with registered count and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_r      <= REPOSO;
            cuenta_r      <= {W{1'b0}};
            activo_r      <= 1'b0;
            fin_r         <= 1'b0;
            error_carga_r <= 1'b0;
        end else begin
            fin_r         <= 1'b0;
            error_carga_r <= 1'b0;
            if (cargar) begin
                // A rejected load leaves count and state untouched.
                if (valor_valido_s) begin
                    cuenta_r <= valor;
                    estado_r <= REPOSO;
                    activo_r <= 1'b0;
                end else begin
                    error_carga_r <= 1'b1;
                end
            end else begin
                case (estado_r)
                    REPOSO, PAUSA: begin
                        if (!pausar && iniciar && !cuenta_cero_s) begin
                            estado_r <= CORRIENDO;
                            activo_r <= 1'b1;
                        end else begin
                            activo_r <= 1'b0;
                        end
                    end
                    CORRIENDO: begin
                        if (pausar) begin
                            estado_r <= PAUSA;
                            activo_r <= 1'b0;
                        end else if (decremento) begin
                            cuenta_r <= cuenta_dec_s;
                            if (dec_cero_s) begin
                                estado_r <= FIN;
                                activo_r <= 1'b0;
                                fin_r    <= 1'b1;
                            end else begin
                                activo_r <= 1'b1;
                            end
                        end else begin
                            activo_r <= 1'b1;
                        end
                    end
                    FIN: begin
                        cuenta_r <= {W{1'b0}};
                        activo_r <= 1'b0;
                    end
                    default: begin
                        estado_r <= REPOSO;
                        activo_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cuenta      = cuenta_r;
    assign activo      = activo_r;
    assign fin         = fin_r;
    assign error_carga = error_carga_r;

endmodule

// File: tb/tb_bcd_cuenta_regresiva.sv
// Self-checking bench for bcd_cuenta_regresiva: integer-valued reference model
// compared every cycle, plus directed literal checks of key scenarios.
module tb_bcd_cuenta_regresiva;

    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         cargar;
    logic [W-1:0] valor;
    logic         iniciar;
    logic         pausar;
    logic         decremento;
    logic [W-1:0] cuenta;
    logic         activo;
    logic         fin;
    logic         error_carga;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    bcd_cuenta_regresiva #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .cargar(cargar), .valor(valor),
        .iniciar(iniciar), .pausar(pausar), .decremento(decremento),
        .cuenta(cuenta), .activo(activo), .fin(fin), .error_carga(error_carga)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the count is kept as a plain integer.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int   m_n;
    int   m_mode;
    logic m_fin;
    logic m_err;

    function automatic logic [W-1:0] to_bcd(input int n);
        logic [W-1:0] r;
        int p;
        p = 1;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((n / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] v);
        int s, p;
        s = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            s = s + int'(v[4*i +: 4]) * p;
            p = p * 10;
        end
        return s;
    endfunction

    function automatic bit is_valid(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (int'(v[4*i +: 4]) > 9) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_mode = M_IDLE; m_fin = 1'b0; m_err = 1'b0;
        end else begin
            m_fin = 1'b0;
            m_err = 1'b0;
            if (cargar) begin
                if (is_valid(valor)) begin
                    m_n = from_bcd(valor);
                    m_mode = M_IDLE;
                end else begin
                    m_err = 1'b1;
                end
            end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
                if (!pausar && iniciar && m_n != 0) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (pausar) m_mode = M_PAUSE;
                else if (decremento) begin
                    m_n = m_n - 1;
                    if (m_n == 0) begin
                        m_mode = M_DONE;
                        m_fin = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (cuenta !== to_bcd(m_n) || activo !== (m_mode == M_RUN) ||
                fin !== m_fin || error_carga !== m_err) begin
                errors++;
                $display("FAIL model t=%0t cuenta=%h/%h activo=%b/%b fin=%b/%b error_carga=%b/%b (got/required)",
                         $time, cuenta, to_bcd(m_n), activo, (m_mode == M_RUN), fin, m_fin,
                         error_carga, m_err);
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    // Apply inputs for exactly one rising edge, return just after the next falling edge.
    task automatic cyc(input logic cg, input logic [W-1:0] v, input logic ini,
                       input logic pau, input logic dec);
        cargar = cg; valor = v; iniciar = ini; pausar = pau; decremento = dec;
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cargar = 1'b0; valor = '0; iniciar = 1'b0; pausar = 1'b0; decremento = 1'b0;
        @(negedge clk); #2;
        rst = 1'b0;
        chk("rst_cuenta", cuenta, 16'h0000);
        chk("rst_flags", {13'd0, activo, fin, error_carga}, 16'h0000);
        chk_en = 1'b1;

        // Scenario 1: 3 -> 0
        cyc(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
        chk("s1_load", cuenta, 16'h0003);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("s1_activo", {15'd0, activo}, 16'h0001);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s1_t1", cuenta, 16'h0002);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s1_t2", {cuenta[11:0], 3'b000, fin}, {12'h001, 4'h0});
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s1_t3", {cuenta[11:0], 2'b00, activo, fin}, {12'h000, 4'h1});
        idle();
        chk("s1_fin_drop", {15'd0, fin}, 16'h0000);

        // Scenario 5a: FIN ignores ticks and iniciar
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("s5_fin_hold", {cuenta[11:0], 2'b00, activo, fin}, 16'h0000);

        // Scenario 2: borrow through three digits
        cyc(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s2_borrow", cuenta, 16'h0999);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s2_second", cuenta, 16'h0998);

        // Scenario 3: rejected loads, held for two cycles
        cyc(1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0);
        chk("s3_err", {15'd0, error_carga}, 16'h0001);
        chk("s3_keep", cuenta, 16'h0998);
        cyc(1'b1, 16'hF000, 1'b0, 1'b0, 1'b1);
        chk("s3_err_held", {14'd0, error_carga, activo}, 16'h0003);
        idle();
        chk("s3_err_drop", {15'd0, error_carga}, 16'h0000);

        // Scenario 4: pause discards the simultaneous tick
        cyc(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("s4_pause", {cuenta[11:0], 3'b000, activo}, {12'h010, 4'h0});
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s4_tick_paused", cuenta, 16'h0010);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s4_resume", cuenta, 16'h0009);

        // Load while running stops counting
        cyc(1'b1, 16'h0042, 1'b0, 1'b0, 1'b1);
        chk("load_running", {cuenta[11:0], 3'b000, activo}, {12'h042, 4'h0});

        // Scenario 5b: zero preset cannot start
        cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("s5_zero_start", {15'd0, activo}, 16'h0000);

        // Long run through several borrows
        cyc(1'b1, 16'h2003, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) cyc(1'b0, '0, 1'b0, 1'b0, (i % 5) != 4);
        chk("long_run", cuenta, 16'h1983);

        // Scenario 6: asynchronous reset between edges
        cyc(1'b1, 16'h0500, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s6_before", cuenta, 16'h0498);
        decremento = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("s6_async", {cuenta[11:0], 3'b000, activo}, 16'h0000);
        @(negedge clk); #2;
        rst = 1'b0;
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("s6_no_resume", {cuenta[11:0], 3'b000, activo}, 16'h0000);
        cyc(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("s6_restart", cuenta, 16'h0006);
        idle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
